// File: rtl/eth_uart_pkg.sv
// Shared definitions for the Ethernet-byte-to-UART bridge: FSM state codes and baud divisor math.
// The PARITY state is only reached when UART_TX_PARITY_EN is defined.
package eth_uart_pkg;

  typedef logic [2:0] uart_state_t;

  localparam uart_state_t ST_IDLE   = 3'd0;
  localparam uart_state_t ST_START  = 3'd1;
  localparam uart_state_t ST_DATA   = 3'd2;
  localparam uart_state_t ST_PARITY = 3'd3;
  localparam uart_state_t ST_STOP   = 3'd4;

  // Rounded clocks-per-bit, so the bit time error stays within half a clock.
  function automatic int calc_div(input int clk_hz, input int baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/byte_fifo.sv
// Synchronous byte FIFO, depth 2^AW, registered (non show-ahead) read data.
// Pushes while full and pops while empty are ignored.
module byte_fifo #(
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic [7:0]    push_data,
  input  logic          pop,
  output logic [7:0]    pop_data,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   level
);

  localparam int          DEPTH   = 1 << AW;
  localparam logic [AW:0] DEPTH_L = (AW + 1)'(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push_ok;
  logic          pop_ok;

  assign full    = (level == DEPTH_L);
  assign empty   = (level == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Level holds when an accepted push and pop land in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      pop_data <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop_ok) begin
        pop_data <= mem[rd_ptr];
        rd_ptr   <= rd_ptr + 1'b1;
      end
      case ({push_ok, pop_ok})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/eth_uart_tx.sv
// Buffers received Ethernet bytes and sends them out as 8N1 UART frames, dropping on overflow.
// Define UART_TX_PARITY_EN to insert an even-parity bit (8E1).
module eth_uart_tx
  import eth_uart_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 25000000,
  parameter int BAUD        = 115200,
  parameter int FIFO_AW     = 4
) (
  input  logic               phy_rx_clk,
  input  logic               reset,
  input  logic [7:0]         rx_data_in,
  input  logic               rx_data_valid,
  output logic               uart_tx,
  output logic               tx_busy,
  output logic [FIFO_AW:0]   fifo_level,
  output logic               overflow,
  output logic [15:0]        drop_count
);

  localparam int          DIV      = calc_div(CLK_FREQ_HZ, BAUD);
  localparam int          CW       = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] DIV_LAST = CW'(DIV - 1);

  uart_state_t   state;
  logic [CW-1:0] baud_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift_reg;
  logic          load;
  logic          pop;
  logic          baud_done;
  logic          fifo_full;
  logic          fifo_empty;
  logic [7:0]    fifo_dout;
`ifdef UART_TX_PARITY_EN
  logic          parity_bit;
`endif

  byte_fifo #(.AW(FIFO_AW)) u_fifo (
    .clk       (phy_rx_clk),
    .reset     (reset),
    .push      (rx_data_valid),
    .push_data (rx_data_in),
    .pop       (pop),
    .pop_data  (fifo_dout),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  assign baud_done = (baud_cnt == DIV_LAST);
  assign tx_busy   = (state != ST_IDLE);
  assign pop       = !fifo_empty &&
                     ((state == ST_IDLE) || ((state == ST_STOP) && baud_done));

  always_ff @(posedge phy_rx_clk) begin
    if (reset) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end else if (rx_data_valid && fifo_full) begin
      overflow <= 1'b1;
      if (drop_count != 16'hFFFF) begin
        drop_count <= drop_count + 16'd1;
      end
    end
  end

  // FIFO read data appears the cycle after the pop, so the shift register loads one cycle late.
  always_ff @(posedge phy_rx_clk) begin
    if (reset) begin
      load <= 1'b0;
    end else begin
      load <= pop;
    end
  end

  always_ff @(posedge phy_rx_clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      baud_cnt  <= '0;
      bit_idx   <= '0;
      shift_reg <= '0;
      uart_tx   <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_bit <= 1'b0;
`endif
    end else begin
      if (load) begin
        shift_reg <= fifo_dout;
`ifdef UART_TX_PARITY_EN
        parity_bit <= ^fifo_dout;
`endif
      end
      case (state)
        ST_IDLE: begin
          uart_tx  <= 1'b1;
          baud_cnt <= '0;
          if (!fifo_empty) begin
            state   <= ST_START;
            uart_tx <= 1'b0;
          end
        end
        ST_START: begin
          if (baud_done) begin
            state    <= ST_DATA;
            baud_cnt <= '0;
            bit_idx  <= '0;
            uart_tx  <= shift_reg[0];
          end else begin
            baud_cnt <= baud_cnt + CW'(1);
          end
        end
        ST_DATA: begin
          if (baud_done) begin
            baud_cnt <= '0;
            if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              state   <= ST_PARITY;
              uart_tx <= parity_bit;
`else
              state   <= ST_STOP;
              uart_tx <= 1'b1;
`endif
            end else begin
              bit_idx   <= bit_idx + 3'd1;
              uart_tx   <= shift_reg[1];
              shift_reg <= {1'b0, shift_reg[7:1]};
            end
          end else begin
            baud_cnt <= baud_cnt + CW'(1);
          end
        end
`ifdef UART_TX_PARITY_EN
        ST_PARITY: begin
          if (baud_done) begin
            state    <= ST_STOP;
            baud_cnt <= '0;
            uart_tx  <= 1'b1;
          end else begin
            baud_cnt <= baud_cnt + CW'(1);
          end
        end
`endif
        // Chain straight into the next START when more bytes are waiting.
        ST_STOP: begin
          if (baud_done) begin
            baud_cnt <= '0;
            if (!fifo_empty) begin
              state   <= ST_START;
              uart_tx <= 1'b0;
            end else begin
              state   <= ST_IDLE;
              uart_tx <= 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt + CW'(1);
          end
        end
        default: begin
          state    <= ST_IDLE;
          baud_cnt <= '0;
          uart_tx  <= 1'b1;
        end
      endcase
    end
  end

endmodule
